// File: rtl/lsu_mem_access_pkg.sv
// Shared constants, state encoding and decode helpers for the load/store unit.
package lsu_mem_access_pkg;

   localparam logic [6:0] OpcLoad  = 7'b0000011;
   localparam logic [6:0] OpcStore = 7'b0100011;

   localparam logic [2:0] F3Byte  = 3'b000;
   localparam logic [2:0] F3Half  = 3'b001;
   localparam logic [2:0] F3Word  = 3'b010;
   localparam logic [2:0] F3ByteU = 3'b100;
   localparam logic [2:0] F3HalfU = 3'b101;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StReq   = 2'd1,
      StWaitR = 2'd2,
      StDone  = 2'd3
   } lsu_state_e;

   function automatic logic load_f3_ok(logic [2:0] f3);
      return f3 inside {F3Byte, F3Half, F3Word, F3ByteU, F3HalfU};
   endfunction

   function automatic logic store_f3_ok(logic [2:0] f3);
      return f3 inside {F3Byte, F3Half, F3Word};
   endfunction

   // funct3[1:0] carries the access size for both signed and unsigned loads.
   function automatic logic is_misaligned(logic [2:0] f3, logic [1:0] lo);
      logic mis;
      mis = 1'b0;
      case (f3[1:0])
         2'b01:   mis = lo[0];
         2'b10:   mis = (lo != 2'b00);
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/lsu_mem_access_if.sv
// Word-wide req/gnt/rvalid memory bus between the LSU (master) and memory (slave).
interface lsu_mem_access_if;

   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_gnt;
   logic        bus_rvalid;
   logic [31:0] bus_rdata;

   modport master (
      output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
      input  bus_gnt, bus_rvalid, bus_rdata
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
      output bus_gnt, bus_rvalid, bus_rdata
   );

endinterface

// File: rtl/lsu_mem_access_lane_align.sv
// Combinational lane steering: byte enables and store replication, load extraction/extension.
module lsu_mem_access_lane_align
   import lsu_mem_access_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic        is_store,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_rep,
   output logic [31:0] ld_ext
);

   logic [7:0]  rd_byte;
   logic [15:0] rd_half;

   assign rd_byte = rdata[{addr_lo, 3'b000} +: 8];
   assign rd_half = rdata[{addr_lo[1], 4'b0000} +: 16];

   always_comb begin
      be        = 4'b0000;
      wdata_rep = '0;
      case (funct3[1:0])
         2'b00: begin
            be        = 4'b0001 << addr_lo;
            wdata_rep = {4{wdata[7:0]}};
         end
         2'b01: begin
            be        = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{wdata[15:0]}};
         end
         default: begin
            be        = 4'b1111;
            wdata_rep = wdata;
         end
      endcase
      // Loads never drive write data onto the bus.
      if (!is_store) begin
         wdata_rep = '0;
      end
   end

   always_comb begin
      ld_ext = '0;
      case (funct3)
         F3Byte:  ld_ext = {{24{rd_byte[7]}}, rd_byte};
         F3Half:  ld_ext = {{16{rd_half[15]}}, rd_half};
         F3Word:  ld_ext = rdata;
         F3ByteU: ld_ext = {24'b0, rd_byte};
         F3HalfU: ld_ext = {16'b0, rd_half};
         default: ld_ext = '0;
      endcase
   end

endmodule

// File: rtl/lsu_mem_access.sv
// Memory-access stage: decodes loads/stores, runs one bus transaction each, stalls the core meanwhile.
module lsu_mem_access
   import lsu_mem_access_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     valid_in,
   input  logic [31:0]              instr,
   input  logic [31:0]              addr,
   input  logic [31:0]              wdata,
   output logic                     stall,
   output logic [31:0]              ld_data,
   output logic                     ld_valid,
   output logic                     misalign_err,
   output logic                     bus_err,
   lsu_mem_access_if.master         bus
);

   localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

   lsu_state_e  state_q;
   logic [31:0] addr_q;
   logic [2:0]  funct3_q;
   logic        is_store_q;
   logic [3:0]  be_q;
   logic [31:0] wdata_q;
   logic [7:0]  cnt_q;
   logic [31:0] ld_data_q;
   logic        ld_valid_q, misalign_q, bus_err_q;

   logic [6:0]  opcode;
   logic [2:0]  f3;
   logic        is_load_in, is_store_in, mem_op, misal;
   logic        in_idle, in_req, timeout_hit;
   logic [2:0]  al_f3;
   logic [1:0]  al_lo;
   logic        al_store;
   logic [3:0]  al_be;
   logic [31:0] al_wdata, al_ld;
   logic        unused_instr_bits;

   assign opcode            = instr[6:0];
   assign f3                = instr[14:12];
   assign unused_instr_bits = ^{instr[31:15], instr[11:7]};

   assign is_load_in  = (opcode == OpcLoad) && load_f3_ok(f3);
   assign is_store_in = (opcode == OpcStore) && store_f3_ok(f3);
   assign mem_op      = valid_in && (is_load_in || is_store_in);
   assign misal       = is_misaligned(f3, addr[1:0]);

   assign in_idle     = (state_q == StIdle);
   assign in_req      = (state_q == StReq);
   // >= so a grant on the final budget cycle still aborts if rvalid never follows.
   assign timeout_hit = (cnt_q >= TimeoutLast);

   // Idle steers the live inputs for latching; afterwards the latched op drives extraction.
   assign al_f3    = in_idle ? f3 : funct3_q;
   assign al_lo    = in_idle ? addr[1:0] : addr_q[1:0];
   assign al_store = in_idle ? is_store_in : is_store_q;

   lsu_mem_access_lane_align u_lane_align (
      .funct3    (al_f3),
      .addr_lo   (al_lo),
      .is_store  (al_store),
      .wdata     (wdata),
      .rdata     (bus.bus_rdata),
      .be        (al_be),
      .wdata_rep (al_wdata),
      .ld_ext    (al_ld)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         addr_q     <= '0;
         funct3_q   <= '0;
         is_store_q <= 1'b0;
         be_q       <= '0;
         wdata_q    <= '0;
         cnt_q      <= '0;
         ld_data_q  <= '0;
         ld_valid_q <= 1'b0;
         misalign_q <= 1'b0;
         bus_err_q  <= 1'b0;
      end else begin
         ld_valid_q <= 1'b0;
         misalign_q <= 1'b0;
         bus_err_q  <= 1'b0;
         case (state_q)
            StIdle: begin
               if (mem_op) begin
                  if (misal) begin
                     misalign_q <= 1'b1;
                     state_q    <= StDone;
                  end else begin
                     addr_q     <= addr;
                     funct3_q   <= f3;
                     is_store_q <= is_store_in;
                     be_q       <= al_be;
                     wdata_q    <= al_wdata;
                     cnt_q      <= '0;
                     state_q    <= StReq;
                  end
               end
            end
            StReq: begin
               cnt_q <= cnt_q + 8'd1;
               if (bus.bus_gnt) begin
                  state_q <= is_store_q ? StDone : StWaitR;
               end else if (timeout_hit) begin
                  bus_err_q <= 1'b1;
                  ld_data_q <= '0;
                  state_q   <= StDone;
               end
            end
            StWaitR: begin
               cnt_q <= cnt_q + 8'd1;
               if (bus.bus_rvalid) begin
                  ld_data_q  <= al_ld;
                  ld_valid_q <= 1'b1;
                  state_q    <= StDone;
               end else if (timeout_hit) begin
                  bus_err_q <= 1'b1;
                  ld_data_q <= '0;
                  state_q   <= StDone;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Reset qualifies stall so the core is released the moment reset asserts.
   assign stall = rst && ((mem_op && in_idle) || in_req || (state_q == StWaitR));

   assign ld_data      = ld_data_q;
   assign ld_valid     = ld_valid_q;
   assign misalign_err = misalign_q;
   assign bus_err      = bus_err_q;

   assign bus.bus_req   = in_req;
   assign bus.bus_we    = in_req && is_store_q;
   assign bus.bus_addr  = in_req ? {addr_q[31:2], 2'b00} : '0;
   assign bus.bus_be    = in_req ? be_q : '0;
   assign bus.bus_wdata = in_req ? wdata_q : '0;

endmodule

// File: tb/tb_lsu_mem_access.sv
// Directed self-checking bench for lsu_mem_access with a short timeout budget.
module tb_lsu_mem_access;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_in;
   logic [31:0] instr, addr, wdata;
   logic        stall, ld_valid, misalign_err, bus_err;
   logic [31:0] ld_data;
   int          checks = 0;
   int          errors = 0;

   lsu_mem_access_if bif ();

   lsu_mem_access #(.TIMEOUT_CYCLES(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .valid_in     (valid_in),
      .instr        (instr),
      .addr         (addr),
      .wdata        (wdata),
      .stall        (stall),
      .ld_data      (ld_data),
      .ld_valid     (ld_valid),
      .misalign_err (misalign_err),
      .bus_err      (bus_err),
      .bus          (bif)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mk(logic [6:0] opc, logic [2:0] f3);
      return {17'b0, f3, 5'b0, opc};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; valid_in = 1'b0; instr = '0; addr = '0; wdata = '0;
      bif.bus_gnt = 1'b0; bif.bus_rvalid = 1'b0; bif.bus_rdata = '0;
      step(); step();
      @(negedge clk);
      checks++; if ({stall, ld_valid, misalign_err, bus_err, bif.bus_req} !== 5'b0) begin
         errors++; $display("FAIL reset_flags got %b want 00000",
                            {stall, ld_valid, misalign_err, bus_err, bif.bus_req}); end
      checks++; if (ld_data !== 32'h0) begin
         errors++; $display("FAIL reset_ld_data got %h want 00000000", ld_data); end
      step();
      rst = 1'b1;
      step();
   endtask

   task automatic test_store_word();
      int nstall = 0;
      valid_in = 1'b1; instr = mk(7'b0100011, 3'b010); addr = 32'h104; wdata = 32'hDEADBEEF;
      @(negedge clk); nstall += int'(stall);
      checks++; if (bif.bus_req !== 1'b0) begin
         errors++; $display("FAIL sw_idle_req got %b want 0", bif.bus_req); end
      step(); @(negedge clk); nstall += int'(stall);
      checks++; if ({bif.bus_req, bif.bus_we, bif.bus_be} !== 6'b111111) begin
         errors++; $display("FAIL sw_req_we_be got %b want 111111",
                            {bif.bus_req, bif.bus_we, bif.bus_be}); end
      checks++; if (bif.bus_addr !== 32'h104 || bif.bus_wdata !== 32'hDEADBEEF) begin
         errors++; $display("FAIL sw_addr_data got %h %h want 00000104 deadbeef",
                            bif.bus_addr, bif.bus_wdata); end
      step(); bif.bus_gnt = 1'b1;
      @(negedge clk); nstall += int'(stall);
      step(); bif.bus_gnt = 1'b0;
      @(negedge clk); nstall += int'(stall);
      checks++; if (nstall !== 3) begin
         errors++; $display("FAIL sw_stall_cycles got %0d want 3", nstall); end
      checks++; if (ld_valid !== 1'b0 || bif.bus_req !== 1'b0) begin
         errors++; $display("FAIL sw_done got ld_valid=%b req=%b want 0 0", ld_valid, bif.bus_req); end
      valid_in = 1'b0;
      step();
   endtask

   task automatic test_load_byte(input logic [2:0] f3, input logic [31:0] exp, input string nm);
      valid_in = 1'b1; instr = mk(7'b0000011, f3); addr = 32'h103;
      step(); @(negedge clk);
      checks++; if ({bif.bus_req, bif.bus_we, bif.bus_be} !== 6'b101000 || bif.bus_addr !== 32'h100
                    || bif.bus_wdata !== 32'h0) begin
         errors++; $display("FAIL %s_req got %b %h %h want 101000 00000100 00000000", nm,
                            {bif.bus_req, bif.bus_we, bif.bus_be}, bif.bus_addr, bif.bus_wdata); end
      bif.bus_gnt = 1'b1;
      step(); bif.bus_gnt = 1'b0;
      @(negedge clk);
      checks++; if (bif.bus_req !== 1'b0 || stall !== 1'b1) begin
         errors++; $display("FAIL %s_wait got req=%b stall=%b want 0 1", nm, bif.bus_req, stall); end
      bif.bus_rvalid = 1'b1; bif.bus_rdata = 32'h80FF_0000;
      step(); bif.bus_rvalid = 1'b0; bif.bus_rdata = '0; valid_in = 1'b0;
      @(negedge clk);
      checks++; if (ld_valid !== 1'b1 || ld_data !== exp || stall !== 1'b0) begin
         errors++; $display("FAIL %s_done got v=%b d=%h s=%b want 1 %h 0", nm, ld_valid, ld_data,
                            stall, exp); end
      step(); @(negedge clk);
      checks++; if (ld_valid !== 1'b0 || ld_data !== exp) begin
         errors++; $display("FAIL %s_hold got v=%b d=%h want 0 %h", nm, ld_valid, ld_data, exp); end
      step();
   endtask

   task automatic test_store_half_misalign();
      valid_in = 1'b1; instr = mk(7'b0100011, 3'b001); addr = 32'h202; wdata = 32'h0000_1234;
      step(); @(negedge clk);
      checks++; if (bif.bus_be !== 4'b1100 || bif.bus_wdata !== 32'h12341234
                    || bif.bus_addr !== 32'h200) begin
         errors++; $display("FAIL sh_lanes got %b %h %h want 1100 12341234 00000200",
                            bif.bus_be, bif.bus_wdata, bif.bus_addr); end
      bif.bus_gnt = 1'b1;
      step(); bif.bus_gnt = 1'b0;
      instr = mk(7'b0000011, 3'b001); addr = 32'h201;
      step(); @(negedge clk);
      checks++; if (stall !== 1'b1 || bif.bus_req !== 1'b0) begin
         errors++; $display("FAIL lh_mis_idle got s=%b req=%b want 1 0", stall, bif.bus_req); end
      step(); valid_in = 1'b0;
      @(negedge clk);
      checks++; if ({misalign_err, bif.bus_req, stall, ld_valid} !== 4'b1000) begin
         errors++; $display("FAIL lh_mis_done got %b want 1000",
                            {misalign_err, bif.bus_req, stall, ld_valid}); end
      step(); @(negedge clk);
      checks++; if (misalign_err !== 1'b0) begin
         errors++; $display("FAIL lh_mis_pulse got %b want 0", misalign_err); end
      step();
   endtask

   task automatic test_timeout();
      int nreq = 0;
      logic done = 1'b0;
      valid_in = 1'b1; instr = mk(7'b0000011, 3'b010); addr = 32'h300;
      step();
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         nreq += int'(bif.bus_req);
         if (!stall) done = 1'b1;
         else step();
      end
      valid_in = 1'b0;
      checks++; if (done !== 1'b1 || nreq !== 4) begin
         errors++; $display("FAIL timeout_req_cycles got done=%b n=%0d want 1 4", done, nreq); end
      checks++; if ({bus_err, bif.bus_req, ld_valid} !== 3'b100 || ld_data !== 32'h0) begin
         errors++; $display("FAIL timeout_done got %b %h want 100 00000000",
                            {bus_err, bif.bus_req, ld_valid}, ld_data); end
      step(); @(negedge clk);
      checks++; if (bus_err !== 1'b0) begin
         errors++; $display("FAIL timeout_pulse got %b want 0", bus_err); end
      step();
   endtask

   task automatic test_reset_mid();
      valid_in = 1'b1; instr = mk(7'b0000011, 3'b010); addr = 32'h400;
      step(); bif.bus_gnt = 1'b1;
      step(); bif.bus_gnt = 1'b0;
      #2 rst = 1'b0;
      #1;
      checks++; if (stall !== 1'b0 || bif.bus_req !== 1'b0) begin
         errors++; $display("FAIL rst_mid got s=%b req=%b want 0 0", stall, bif.bus_req); end
      valid_in = 1'b0;
      step(); rst = 1'b1;
      bif.bus_rvalid = 1'b1; bif.bus_rdata = 32'hCAFE_F00D;
      step(); bif.bus_rvalid = 1'b0;
      @(negedge clk);
      checks++; if (ld_valid !== 1'b0 || stall !== 1'b0 || ld_data !== 32'h0) begin
         errors++; $display("FAIL rst_stray_rvalid got v=%b s=%b d=%h want 0 0 00000000",
                            ld_valid, stall, ld_data); end
      step();
      valid_in = 1'b1; addr = 32'h404;
      step(); bif.bus_gnt = 1'b1;
      step(); bif.bus_gnt = 1'b0; bif.bus_rvalid = 1'b1; bif.bus_rdata = 32'h1234_5678;
      step(); bif.bus_rvalid = 1'b0; valid_in = 1'b0;
      @(negedge clk);
      checks++; if (ld_valid !== 1'b1 || ld_data !== 32'h1234_5678) begin
         errors++; $display("FAIL rst_next_lw got v=%b d=%h want 1 12345678", ld_valid, ld_data); end
      step();
   endtask

   task automatic test_non_mem();
      valid_in = 1'b1; instr = mk(7'b0110011, 3'b000); addr = 32'h500;
      #1;
      checks++; if (stall !== 1'b0) begin
         errors++; $display("FAIL add_stall got %b want 0", stall); end
      step(); @(negedge clk);
      checks++; if (bif.bus_req !== 1'b0 || stall !== 1'b0) begin
         errors++; $display("FAIL add_bus got req=%b s=%b want 0 0", bif.bus_req, stall); end
      instr = mk(7'b0000011, 3'b011);
      step(); @(negedge clk);
      checks++; if (stall !== 1'b0) begin
         errors++; $display("FAIL ld_f3_011_stall got %b want 0", stall); end
      step(); @(negedge clk);
      checks++; if (bif.bus_req !== 1'b0) begin
         errors++; $display("FAIL ld_f3_011_req got %b want 0", bif.bus_req); end
      valid_in = 1'b0;
      step();
   endtask

   task automatic test_back_to_back();
      valid_in = 1'b1; instr = mk(7'b0100011, 3'b000); addr = 32'h501; wdata = 32'h0000_00AB;
      step(); @(negedge clk);
      checks++; if ({bif.bus_we, bif.bus_be} !== 5'b10010 || bif.bus_wdata !== 32'hABABABAB) begin
         errors++; $display("FAIL b2b_sb got %b %h want 10010 abababab",
                            {bif.bus_we, bif.bus_be}, bif.bus_wdata); end
      bif.bus_gnt = 1'b1;
      step(); bif.bus_gnt = 1'b0;
      instr = mk(7'b0000011, 3'b101); addr = 32'h502;
      @(negedge clk);
      checks++; if (stall !== 1'b0) begin
         errors++; $display("FAIL b2b_done_stall got %b want 0", stall); end
      step(); @(negedge clk);
      checks++; if (stall !== 1'b1 || bif.bus_req !== 1'b0) begin
         errors++; $display("FAIL b2b_idle got s=%b req=%b want 1 0", stall, bif.bus_req); end
      step(); @(negedge clk);
      checks++; if ({bif.bus_req, bif.bus_we, bif.bus_be} !== 6'b101100) begin
         errors++; $display("FAIL b2b_lhu_req got %b want 101100",
                            {bif.bus_req, bif.bus_we, bif.bus_be}); end
      bif.bus_gnt = 1'b1;
      step(); bif.bus_gnt = 1'b0; bif.bus_rvalid = 1'b1; bif.bus_rdata = 32'hBEEF_0000;
      step(); bif.bus_rvalid = 1'b0; valid_in = 1'b0;
      @(negedge clk);
      checks++; if (ld_valid !== 1'b1 || ld_data !== 32'h0000_BEEF) begin
         errors++; $display("FAIL b2b_lhu_data got v=%b d=%h want 1 0000beef", ld_valid, ld_data); end
      step();
   endtask

   initial begin
      test_reset();
      test_store_word();
      test_load_byte(3'b000, 32'hFFFF_FF80, "lb");
      test_load_byte(3'b100, 32'h0000_0080, "lbu");
      test_store_half_misalign();
      test_timeout();
      test_reset_mid();
      test_non_mem();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
